// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
// Holds FSM encodings and parameter defaults.
package fetch_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 10;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } fetch_state_e;

  // Word-aligned byte address from an arbitrary target.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: pc, one-entry output slot,
// redirect/halt handling and transfer counter.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] PC_MASK =
    32'((64'd1 << (ADDR_WIDTH + 2)) - 64'd1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  out_q, out_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         mis_q, mis_d;
  logic [31:0]  cnt_q, cnt_d;

  logic         xfer;
  logic         slot_free;
  logic [31:0]  pc_inc;
  logic [31:0]  redir_al;
  logic         redir_bad;

  assign xfer      = valid_q & inst_ready;
  assign slot_free = ~valid_q | inst_ready;
  assign pc_inc    = (pc_q + 32'd4) & PC_MASK;
  assign redir_al  = align_pc(redirect_pc);
  assign redir_bad = |redirect_pc[1:0];

  // Next-state, slot and counter logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    out_d   = out_q;
    ipc_d   = ipc_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    if (xfer) cnt_d = cnt_q + 32'd1;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_valid) begin
          pc_d    = redir_al;
          valid_d = 1'b0;
          if (redir_bad) mis_d = 1'b1;
          if (halt_req) state_d = S_HALTED;
        end else if (halt_req) begin
          if (!slot_free) begin
            state_d = S_DRAIN;
          end else begin
            valid_d = 1'b0;
            state_d = S_HALTED;
          end
        end else if (slot_free) begin
          out_d   = rom_data;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_inc;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          pc_d    = redir_al;
          valid_d = 1'b0;
          if (redir_bad) mis_d = 1'b1;
          state_d = S_HALTED;
        end else if (inst_ready) begin
          valid_d = 1'b0;
          state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        if (start && !halt_req) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      out_q   <= '0;
      ipc_q   <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      ipc_q   <= ipc_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_addr     = pc_q;
  assign inst_valid   = valid_q;
  assign inst_out     = out_q;
  assign inst_pc      = ipc_q;
  assign halted       = (state_q == S_HALTED);
  assign misalign_err = mis_q;
  assign fetch_count  = cnt_q;

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, is the word-address width of the instruction ROM (2**ADDR_WIDTH words).
REQ-002 Parameter RESET_PC, default 32'h00000000, is the byte address fetched first after reset; it is word-aligned.
REQ-003 Port clock  in  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  is the asynchronous, active-low reset; the block is in reset while reset==0.
REQ-005 Port start  in  1  is a fetch-enable pulse; it is sampled in IDLE and HALTED.
REQ-006 Port rom_addr  out  32  is the byte address driven to the ROM; the ROM returns endian-corrected data combinationally.
REQ-007 Port rom_data  in  32  is the instruction word for rom_addr, valid in the same cycle.
REQ-008 Port inst_valid  out  1  is high while inst_out/inst_pc hold an instruction for decode.
REQ-009 Port inst_ready  in  1  is the decode accept; a transfer occurs on a cycle with inst_valid && inst_ready.
REQ-010 Port inst_out  out  32  is the registered instruction.
REQ-011 Port inst_pc  out  32  is the byte address of inst_out.
REQ-012 Port redirect_valid  in  1  is a one-cycle branch/jump request.
REQ-013 Port redirect_pc  in  32  is the redirect target byte address.
REQ-014 Port halt_req  in  1  is a level request to stop fetching.
REQ-015 Port halted  out  1  is high only in state HALTED.
REQ-016 Port misalign_err  out  1  is a sticky flag for a redirect target with bits [1:0] != 0.
REQ-017 Port fetch_count  out  32  counts accepted transfers.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, DRAIN and HALTED.
REQ-019 rom_addr SHALL equal the pc register combinationally in every state.
REQ-020 In IDLE, start SHALL move the FSM to FETCH; inst_valid SHALL stay 0 in IDLE.
REQ-021 In FETCH, when the output slot is free (inst_valid==0 or inst_ready==1), the block SHALL load inst_out<=rom_data, inst_pc<=pc, inst_valid<=1 and pc<=pc+4.
REQ-022 Fetch latency SHALL be one cycle: the word addressed in cycle N appears on inst_out in cycle N+1.
REQ-023 With a free slot every cycle, the block SHALL sustain one instruction per cycle.
REQ-024 When inst_valid && !inst_ready, the block SHALL hold pc, inst_out, inst_pc and inst_valid unchanged.
REQ-025 pc increments SHALL wrap within ADDR_WIDTH+2 bits: byte address 4*2**ADDR_WIDTH-4 plus 4 gives 0, and pc[31:ADDR_WIDTH+2] SHALL stay 0.
REQ-026 redirect_valid in FETCH or DRAIN SHALL have priority over fetch: pc<={redirect_pc[31:2],2'b00} and inst_valid<=0 (flush) on the next edge, including during a stall.
REQ-027 A redirect with redirect_pc[1:0]!=0 SHALL set misalign_err to 1 until reset.
REQ-028 redirect_valid SHALL be ignored in IDLE and HALTED.
REQ-029 halt_req in FETCH SHALL stop new fetches; the FSM SHALL go to DRAIN if inst_valid==1 and the slot is not freed, otherwise to HALTED with inst_valid<=0.
REQ-030 In DRAIN, the block SHALL hold the pending output until inst_ready, then clear inst_valid and enter HALTED.
REQ-031 When redirect and halt_req occur in the same cycle, the block SHALL apply the redirect pc, flush, and enter HALTED.
REQ-032 start in HALTED with halt_req==0 SHALL resume FETCH at the current pc.
REQ-033 fetch_count SHALL increment by 1 per transfer and wrap modulo 2**32.

Reset
REQ-034 While reset==0, the block SHALL immediately set state=IDLE, pc=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0, halted=0, misalign_err=0 and fetch_count=0, independent of clock.
REQ-035 Reset asserted mid-fetch or mid-stall SHALL discard the pending instruction; no transfer occurs in the deassertion cycle.

Structure
REQ-036 The state encodings and the RESET_PC/ADDR_WIDTH defaults SHALL reside in a shared package, fetch_pkg.
REQ-037 The block SHALL be a single module with no sub-modules; the ROM is instantiated outside it.

Verification
REQ-038 Reset, start, inst_ready=1, ROM words 0..3 = 200A4000,014A5020,014A5020,014A5020 -> inst_out shows those words on 4 consecutive cycles with inst_pc 0,4,8,C.
REQ-039 inst_ready=0 for 3 cycles at inst_pc=8 -> inst_out, inst_pc and rom_addr=C are frozen; no count change; the next transfer is pc 8.
REQ-040 redirect_pc=0x40 during a stall -> inst_valid drops next cycle, then inst_pc=0x40; redirect_pc=0x42 -> misalign_err=1 and fetch resumes at 0x40.
REQ-041 ADDR_WIDTH=4, run past 0x3C -> the next inst_pc is 0x00.
REQ-042 halt_req with inst_ready=0 -> DRAIN holds the word; inst_ready=1 -> halted=1 next cycle; start -> resume at the saved pc.
REQ-043 reset pulsed low asynchronously mid-fetch -> all outputs are 0 before the next clock edge, and pc=RESET_PC.
